// File: rtl/processor_pkg.sv
// ---------------------------------------------------------------------------
// processor_pkg
// Shared definitions for the instruction sequencer slice:
//   - default widths for the PC, instruction word and opcode field
//   - default memory-acknowledge timeout (only meaningful when the design is
//     built with SEQ_TIMEOUT_EN defined)
//   - opcode constants recognised by the sequencer or its neighbours
//   - the sequencer state enumeration
// ---------------------------------------------------------------------------
package processor_pkg;

    localparam int SEQ_ADDR_W   = 10;
    localparam int SEQ_INSTR_W  = 32;
    localparam int SEQ_OPCODE_W = 4;
    localparam int SEQ_TMO_CYC  = 15;

    localparam logic [SEQ_OPCODE_W-1:0] OP_HLT = 4'hF;
    localparam logic [SEQ_OPCODE_W-1:0] OP_JMP = 4'hE;
    localparam logic [SEQ_OPCODE_W-1:0] OP_BEQ = 4'hD;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_WAIT_MEM  = 3'd2,
        S_DECODE    = 3'd3,
        S_EXECUTE   = 3'd4,
        S_UPDATE_PC = 3'd5,
        S_HALT      = 3'd6,
        S_FAULT     = 3'd7
    } seq_state_t;

endpackage

// File: rtl/seq_timeout_ctr.sv
// ---------------------------------------------------------------------------
// seq_timeout_ctr
// Down-counter that bounds how long the sequencer waits for mem_ack.
// Only instantiated when the sequencer is built with SEQ_TIMEOUT_EN defined.
//
// Ports:
//   clock      in   rising-edge clock
//   i_clear    in   synchronous active-high clear
//   i_load     in   reload the counter with TMO_CYC (cycle before WAIT_MEM)
//   i_count    in   one waiting cycle without acknowledge
//   o_expired  out  high in the TMO_CYC-th counted cycle
// ---------------------------------------------------------------------------
module seq_timeout_ctr
    import processor_pkg::*;
#(
    parameter int TMO_CYC = SEQ_TMO_CYC
) (
    input  logic clock,
    input  logic i_clear,
    input  logic i_load,
    input  logic i_count,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TMO_CYC + 1);

    logic [CNT_W-1:0] r_count;

    // The counter holds the number of waiting cycles still allowed. It is
    // reloaded while the request is being issued, so the first WAIT_MEM
    // cycle sees the full budget, and it saturates at zero.
    always_ff @(posedge clock) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= CNT_W'(TMO_CYC);
        end else if (i_count && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Expiry is flagged in the last allowed cycle so the sequencer can leave
    // WAIT_MEM on that same edge; an acknowledge in that cycle suppresses it.
    assign o_expired = i_count && (r_count == CNT_W'(1));

endmodule

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
// Fetch/decode/execute controller for the program counter. Requests an
// instruction at fetch_addr, latches it, hands the opcode to the execute
// stage and then steps the PC (+1 through the counter) or loads a branch
// target. It is the only driver of PC_ENABLE, JMP_SGNL and ADDRESS.
//
// Optional feature: define SEQ_TIMEOUT_EN to bound the wait for mem_ack to
// TMO_CYC cycles; on expiry the sequencer enters a sticky FAULT state.
// Without it, WAIT_MEM waits forever and fault is tied low.
//
// Ports:
//   clock, CLEAR                  clock and synchronous active-high reset
//   START                         begin fetching from IDLE or resume from HALT
//   mem_req/mem_addr              instruction read request and address
//   mem_ack/mem_rdata             read completion and instruction data
//   instr/opcode                  instruction register and its opcode field
//   exec_start/exec_done          handshake with the execute stage
//   branch_taken/branch_target    PC redirect, sampled with exec_done
//   PC_RESULT                     counter output (current PC + 1)
//   PC_ENABLE/JMP_SGNL/ADDRESS    counter load strobe, mux select, load value
//   fetch_addr                    shadow copy of the counter register
//   busy/halted/fault             status flags
// ---------------------------------------------------------------------------
module instr_sequencer
    import processor_pkg::*;
#(
    parameter int ADDR_W   = SEQ_ADDR_W,
    parameter int INSTR_W  = SEQ_INSTR_W,
`ifdef SEQ_TIMEOUT_EN
    parameter int TMO_CYC  = SEQ_TMO_CYC,
`endif
    parameter int OPCODE_W = SEQ_OPCODE_W
) (
    input  logic                clock,
    input  logic                CLEAR,
    input  logic                START,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ack,
    input  logic [INSTR_W-1:0]  mem_rdata,
    output logic [INSTR_W-1:0]  instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic                exec_start,
    input  logic                exec_done,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_target,
    input  logic [ADDR_W-1:0]   PC_RESULT,
    output logic                PC_ENABLE,
    output logic                JMP_SGNL,
    output logic [ADDR_W-1:0]   ADDRESS,
    output logic [ADDR_W-1:0]   fetch_addr,
    output logic                busy,
    output logic                halted,
    output logic                fault
);

    seq_state_t          r_state;
    seq_state_t          w_nextState;

    logic                r_memReq;
    logic                r_execStart;
    logic                r_busy;
    logic                r_halted;
    logic [INSTR_W-1:0]  r_instr;
    logic [ADDR_W-1:0]   r_fetchAddr;
    logic                r_branchTaken;
    logic [ADDR_W-1:0]   r_branchTarget;

    logic [OPCODE_W-1:0] w_opcode;
    logic [OPCODE_W-1:0] w_rdataOpcode;
    logic                w_timeout;
    logic                w_pcEnable;
    logic                w_jmpSgnl;
    logic [ADDR_W-1:0]   w_address;

    assign w_opcode      = r_instr[INSTR_W-1 -: OPCODE_W];
    assign w_rdataOpcode = mem_rdata[INSTR_W-1 -: OPCODE_W];

`ifdef SEQ_TIMEOUT_EN
    logic r_fault;
    logic w_tmoLoad;
    logic w_tmoCount;

    // The budget is loaded while the request is issued and consumed only by
    // WAIT_MEM cycles that see no acknowledge.
    assign w_tmoLoad  = (r_state == S_FETCH);
    assign w_tmoCount = (r_state == S_WAIT_MEM) && !mem_ack;

    seq_timeout_ctr #(
        .TMO_CYC   (TMO_CYC)
    ) u_timeout (
        .clock     (clock),
        .i_clear   (CLEAR),
        .i_load    (w_tmoLoad),
        .i_count   (w_tmoCount),
        .o_expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state logic. An acknowledge in FETCH is not looked at because the
    // FETCH branch never tests mem_ack; in WAIT_MEM the acknowledge is tested
    // before the timeout so a late ack still completes the read.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            S_IDLE:      if (START)       w_nextState = S_FETCH;
            S_FETCH:                      w_nextState = S_WAIT_MEM;
            S_WAIT_MEM: begin
                if (mem_ack)              w_nextState = S_DECODE;
                else if (w_timeout)       w_nextState = S_FAULT;
            end
            S_DECODE: begin
                if (w_opcode == OP_HLT)   w_nextState = S_HALT;
                else                      w_nextState = S_EXECUTE;
            end
            S_EXECUTE:   if (exec_done)   w_nextState = S_UPDATE_PC;
            S_UPDATE_PC:                  w_nextState = S_FETCH;
            S_HALT:      if (START)       w_nextState = S_FETCH;
            S_FAULT:                      w_nextState = S_FAULT;
            default:                      w_nextState = S_IDLE;
        endcase
    end

    // Counter interface. PC_RESULT comes back combinationally from the
    // counter, so ADDRESS has to follow it in the same cycle rather than
    // through a register. Leaving HALT reuses the +1 path to skip the HLT
    // word before the next fetch is issued.
    always_comb begin
        w_pcEnable = 1'b0;
        w_jmpSgnl  = 1'b1;
        w_address  = '0;
        if (r_state == S_UPDATE_PC) begin
            w_pcEnable = 1'b1;
            w_jmpSgnl  = !r_branchTaken;
            w_address  = r_branchTaken ? r_branchTarget : PC_RESULT;
        end else if ((r_state == S_HALT) && START) begin
            w_pcEnable = 1'b1;
            w_address  = PC_RESULT;
        end
    end

    // State register and registered status/handshake outputs. Each output
    // flop is loaded from the decode of the next state so its value lines up
    // with the state it describes. exec_start can only rise on the
    // WAIT_MEM->DECODE edge, so the opcode test looks at the incoming data.
    always_ff @(posedge clock) begin
        if (CLEAR) begin
            r_state     <= S_IDLE;
            r_memReq    <= 1'b0;
            r_execStart <= 1'b0;
            r_busy      <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_memReq    <= (w_nextState == S_FETCH) || (w_nextState == S_WAIT_MEM);
            r_execStart <= (w_nextState == S_DECODE) && (w_rdataOpcode != OP_HLT);
            r_busy      <= (w_nextState != S_IDLE) && (w_nextState != S_HALT) &&
                           (w_nextState != S_FAULT);
            r_halted    <= (w_nextState == S_HALT);
        end
    end

`ifdef SEQ_TIMEOUT_EN
    // Fault flag mirrors entry into the sticky FAULT state.
    always_ff @(posedge clock) begin
        if (CLEAR) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= (w_nextState == S_FAULT);
        end
    end

    assign fault = r_fault;
`else
    assign fault = 1'b0;
`endif

    // Datapath registers: instruction capture on the acknowledge, branch
    // decision capture on exec_done, and the shadow PC that follows every
    // counter load.
    always_ff @(posedge clock) begin
        if (CLEAR) begin
            r_instr        <= '0;
            r_fetchAddr    <= '0;
            r_branchTaken  <= 1'b0;
            r_branchTarget <= '0;
        end else begin
            if ((r_state == S_WAIT_MEM) && mem_ack) begin
                r_instr <= mem_rdata;
            end
            if ((r_state == S_EXECUTE) && exec_done) begin
                r_branchTaken  <= branch_taken;
                r_branchTarget <= branch_target;
            end
            if (w_pcEnable) begin
                r_fetchAddr <= w_address;
            end
        end
    end

    assign mem_req    = r_memReq;
    assign mem_addr   = r_fetchAddr;
    assign instr      = r_instr;
    assign opcode     = w_opcode;
    assign exec_start = r_execStart;
    assign PC_ENABLE  = w_pcEnable;
    assign JMP_SGNL   = w_jmpSgnl;
    assign ADDRESS    = w_address;
    assign fetch_addr = r_fetchAddr;
    assign busy       = r_busy;
    assign halted     = r_halted;

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
// Directed bench for instr_sequencer with a small model of the external
// program counter (loads ADDRESS on PC_ENABLE, PC_RESULT = PC + 1). Follows
// the build's SEQ_TIMEOUT_EN setting for the timeout scenario.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

    logic        clock;
    logic        CLEAR;
    logic        START;
    logic        mem_req;
    logic [9:0]  mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [3:0]  opcode;
    logic        exec_start;
    logic        exec_done;
    logic        branch_taken;
    logic [9:0]  branch_target;
    logic [9:0]  PC_RESULT;
    logic        PC_ENABLE;
    logic        JMP_SGNL;
    logic [9:0]  ADDRESS;
    logic [9:0]  fetch_addr;
    logic        busy;
    logic        halted;
    logic        fault;

    logic [9:0]  pcReg;
    int          errorCount;
    int          checkCount;

    instr_sequencer dut (
        .clock         (clock),
        .CLEAR         (CLEAR),
        .START         (START),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .instr         (instr),
        .opcode        (opcode),
        .exec_start    (exec_start),
        .exec_done     (exec_done),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .PC_RESULT     (PC_RESULT),
        .PC_ENABLE     (PC_ENABLE),
        .JMP_SGNL      (JMP_SGNL),
        .ADDRESS       (ADDRESS),
        .fetch_addr    (fetch_addr),
        .busy          (busy),
        .halted        (halted),
        .fault         (fault)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // External program counter: cleared with the sequencer, loads ADDRESS on
    // the strobe, and offers PC + 1 (wrapping at 10 bits) back.
    always @(posedge clock) begin
        if (CLEAR) pcReg <= 10'd0;
        else if (PC_ENABLE) pcReg <= ADDRESS;
    end
    assign PC_RESULT = pcReg + 10'd1;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive every sequencer input at once.
    task automatic applyStimulus(input logic start, input logic ack,
                                 input logic [31:0] rdata, input logic done,
                                 input logic taken, input logic [9:0] target);
        START         = start;
        mem_ack       = ack;
        mem_rdata     = rdata;
        exec_done     = done;
        branch_taken  = taken;
        branch_target = target;
    endtask

    // Advance to just after the next rising edge.
    task automatic stepCycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // One full non-halting instruction, entered in FETCH: ack in the first
    // WAIT_MEM cycle, exec_done in the cycle after exec_start, so the
    // sequencer must be back in FETCH exactly five cycles later.
    task automatic runInstr(input string name, input logic [31:0] word,
                            input logic taken, input logic [9:0] target,
                            input logic [9:0] addr, input logic [9:0] nextAddr);
        checkOutput({name, " fetch mem_req"}, mem_req, 1);
        checkOutput({name, " fetch mem_addr"}, mem_addr, addr);
        applyStimulus(0, 0, 32'h0, 0, 0, 10'h0);
        stepCycle(1);
        checkOutput({name, " wait mem_req"}, mem_req, 1);
        applyStimulus(0, 1, word, 0, 0, 10'h0);
        stepCycle(1);
        checkOutput({name, " decode instr"}, instr, word);
        checkOutput({name, " decode opcode"}, opcode, word[31:28]);
        checkOutput({name, " decode exec_start"}, exec_start, 1);
        checkOutput({name, " decode mem_req"}, mem_req, 0);
        applyStimulus(0, 0, 32'h0, 0, 0, 10'h0);
        stepCycle(1);
        checkOutput({name, " execute exec_start"}, exec_start, 0);
        checkOutput({name, " execute PC_ENABLE"}, PC_ENABLE, 0);
        applyStimulus(0, 0, 32'h0, 1, taken, target);
        stepCycle(1);
        checkOutput({name, " update PC_ENABLE"}, PC_ENABLE, 1);
        checkOutput({name, " update JMP_SGNL"}, JMP_SGNL, !taken);
        checkOutput({name, " update ADDRESS"}, ADDRESS, nextAddr);
        applyStimulus(0, 0, 32'h0, 0, 0, 10'h0);
        stepCycle(1);
        checkOutput({name, " next fetch_addr"}, fetch_addr, nextAddr);
        checkOutput({name, " next mem_req"}, mem_req, 1);
        checkOutput({name, " next PC_ENABLE"}, PC_ENABLE, 0);
    endtask

    initial begin
        errorCount = 0;
        checkCount = 0;
        CLEAR = 1'b1;
        applyStimulus(0, 0, 32'h0, 0, 0, 10'h0);
        stepCycle(2);

        // Reset state
        checkOutput("reset mem_req", mem_req, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset halted", halted, 0);
        checkOutput("reset fault", fault, 0);
        checkOutput("reset instr", instr, 0);
        checkOutput("reset fetch_addr", fetch_addr, 0);
        checkOutput("reset PC_ENABLE", PC_ENABLE, 0);
        checkOutput("reset ADDRESS", ADDRESS, 0);
        checkOutput("reset exec_start", exec_start, 0);

        // Sequential step from 0, then branch to 0x2A0, then to 0x3FF
        CLEAR = 1'b0;
        applyStimulus(1, 0, 32'h0, 0, 0, 10'h0);
        stepCycle(1);
        START = 1'b0;
        checkOutput("start busy", busy, 1);
        runInstr("alu0", 32'h1234_5678, 0, 10'h000, 10'h000, 10'h001);
        runInstr("br2a0", 32'hD000_0001, 1, 10'h2A0, 10'h001, 10'h2A0);
        runInstr("br3ff", 32'hE000_0002, 1, 10'h3FF, 10'h2A0, 10'h3FF);

        // Wrap from the top address, then a branch onto itself
        runInstr("wrap", 32'h2000_0003, 0, 10'h000, 10'h3FF, 10'h000);
        runInstr("self", 32'hE000_0004, 1, 10'h000, 10'h000, 10'h000);

        // Halt at address 0, hold, then resume at 1
        applyStimulus(0, 0, 32'h0, 0, 0, 10'h0);
        stepCycle(1);
        applyStimulus(0, 1, 32'hF000_0000, 0, 0, 10'h0);
        stepCycle(1);
        checkOutput("hlt decode exec_start", exec_start, 0);
        applyStimulus(0, 0, 32'h0, 0, 0, 10'h0);
        stepCycle(1);
        checkOutput("hlt halted", halted, 1);
        checkOutput("hlt busy", busy, 0);
        checkOutput("hlt PC_ENABLE", PC_ENABLE, 0);
        stepCycle(2);
        checkOutput("hlt hold halted", halted, 1);
        checkOutput("hlt hold fetch_addr", fetch_addr, 0);
        START = 1'b1;
        #1;
        checkOutput("resume PC_ENABLE", PC_ENABLE, 1);
        checkOutput("resume JMP_SGNL", JMP_SGNL, 1);
        checkOutput("resume ADDRESS", ADDRESS, 10'h001);
        stepCycle(1);
        START = 1'b0;
        checkOutput("resume halted", halted, 0);
        checkOutput("resume mem_req", mem_req, 1);
        checkOutput("resume mem_addr", mem_addr, 10'h001);

        // Clear in the middle of a memory handshake
        stepCycle(1);
        checkOutput("midclr wait mem_req", mem_req, 1);
        CLEAR = 1'b1;
        stepCycle(1);
        CLEAR = 1'b0;
        checkOutput("midclr mem_req", mem_req, 0);
        checkOutput("midclr busy", busy, 0);
        checkOutput("midclr instr", instr, 0);
        checkOutput("midclr fetch_addr", fetch_addr, 0);

        // Memory that never answers
        START = 1'b1;
        stepCycle(1);
        START = 1'b0;
        stepCycle(1);
`ifdef SEQ_TIMEOUT_EN
        stepCycle(14);
        checkOutput("tmo cycle15 fault", fault, 0);
        checkOutput("tmo cycle15 mem_req", mem_req, 1);
        stepCycle(1);
        checkOutput("tmo fault", fault, 1);
        checkOutput("tmo mem_req", mem_req, 0);
        checkOutput("tmo busy", busy, 0);
        START = 1'b1;
        stepCycle(3);
        START = 1'b0;
        checkOutput("tmo sticky fault", fault, 1);
        checkOutput("tmo sticky mem_req", mem_req, 0);
        CLEAR = 1'b1;
        stepCycle(1);
        CLEAR = 1'b0;
        checkOutput("tmo clear fault", fault, 0);

        // Acknowledge in the last allowed cycle wins over the timeout
        START = 1'b1;
        stepCycle(1);
        START = 1'b0;
        stepCycle(15);
        applyStimulus(0, 1, 32'h1000_0000, 0, 0, 10'h0);
        stepCycle(1);
        applyStimulus(0, 0, 32'h0, 0, 0, 10'h0);
        checkOutput("lateack fault", fault, 0);
        checkOutput("lateack exec_start", exec_start, 1);
        checkOutput("lateack instr", instr, 32'h1000_0000);
`else
        stepCycle(100);
        checkOutput("nowait mem_req", mem_req, 1);
        checkOutput("nowait fault", fault, 0);
        checkOutput("nowait busy", busy, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
